uart_tx_arbiter: RTL

- Round-robin arbiter and byte sequencer that shares one UART transmitter among NUM_REQ requesters (accelerator status, layer results, debug).
- Each requester streams a packet of bytes with a valid/ready/last handshake.
- The arbiter locks the grant for the whole packet and optionally prefixes a source-ID header byte.
- It drives the transmitter's start/data_in and tracks its busy output to pace bytes.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one requester for a whole packet and paces its
// bytes, optionally behind a source-ID header, into a shared UART transmitter.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter bit HEADER_EN    = 1'b1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 pkt_active,
  output logic                 timeout_err,
  output logic [2:0]           state_dbg
);

  // Handshake: a requester byte moves on the rising edge where req_valid[i] & req_ready[i];
  // ready is offered only to the granted requester in PAYLOAD and never depends on valid.
  localparam int          TW        = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]  NUM_REQ_W = 4'(NUM_REQ);
  localparam logic [2:0]  LAST_RST  = 3'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_START   = 3'd3,
    S_WAIT_HI = 3'd4,
    S_WAIT_LO = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      last_grant_q, last_grant_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            last_flag_q, last_flag_d;
  logic            pkt_active_q, pkt_active_d;
  logic            timeout_err_q, timeout_err_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  logic [7:0]      valid_ext, last_ext, ready_ext;
  logic [63:0]     data_ext;
  logic [7:0]      data_sel;
  logic [2:0]      rr_pick;
  logic [3:0]      rr_idx;
  logic            rr_found;
  logic            timeout_hit;

  // Widen the per-requester buses to 8 lanes so a 3-bit grant can index them directly.
  always_comb begin
    valid_ext                  = '0;
    last_ext                   = '0;
    data_ext                   = '0;
    valid_ext[NUM_REQ-1:0]     = req_valid;
    last_ext[NUM_REQ-1:0]      = req_last;
    data_ext[8*NUM_REQ-1:0]    = req_data;
    data_sel                   = data_ext[{grant_q, 3'b000} +: 8];
  end

  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant_q;
    rr_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = {1'b0, last_grant_q} + 4'(i);
      if (rr_idx >= NUM_REQ_W) rr_idx = rr_idx - NUM_REQ_W;
      if (!rr_found && valid_ext[rr_idx[2:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx[2:0];
      end
    end
  end

  assign timeout_hit = (state_q == S_WAIT_HI) && !tx_busy && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      last_grant_q  <= LAST_RST;
      tx_data_q     <= '0;
      last_flag_q   <= 1'b0;
      pkt_active_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      tx_data_q     <= tx_data_d;
      last_flag_q   <= last_flag_d;
      pkt_active_q  <= pkt_active_d;
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (|req_valid) state_d = HEADER_EN ? S_HDR : S_PAYLOAD;
      S_HDR:     state_d = S_START;
      S_PAYLOAD: if (valid_ext[grant_q]) state_d = S_START;
      S_START:   state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tx_busy)          state_d = S_WAIT_LO;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WAIT_LO: if (!tx_busy) state_d = last_flag_q ? S_IDLE : S_PAYLOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    tx_data_d     = tx_data_q;
    last_flag_d   = last_flag_q;
    pkt_active_d  = pkt_active_q;
    timeout_err_d = timeout_err_q;
    to_cnt_d      = to_cnt_q;
    ready_ext     = '0;
    tx_start      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_d      = rr_pick;
          pkt_active_d = 1'b1;
        end
      end
      S_HDR: begin
        tx_data_d   = {4'hA, 1'b0, grant_q};
        last_flag_d = 1'b0;
      end
      S_PAYLOAD: begin
        ready_ext[grant_q] = 1'b1;
        if (valid_ext[grant_q]) begin
          tx_data_d   = data_sel;
          last_flag_d = last_ext[grant_q];
        end
      end
      S_START: begin
        tx_start = 1'b1;
        to_cnt_d = '0;
      end
      S_WAIT_HI: begin
        // A transmitter that never goes busy abandons the packet and skips this requester.
        if (timeout_hit) begin
          timeout_err_d = 1'b1;
          pkt_active_d  = 1'b0;
          last_grant_d  = grant_q;
        end else if (!tx_busy) begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy && last_flag_q) begin
          pkt_active_d = 1'b0;
          last_grant_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  assign req_ready   = ready_ext[NUM_REQ-1:0];
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign pkt_active  = pkt_active_q;
  assign timeout_err = timeout_err_q;
  assign state_dbg   = state_q;

endmodule
